// File: rtl/clk_en_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_en_gen_pkg
// Shared types and constants for the lock-qualified fractional clock-enable
// generator: the lock-qualification state enum, the channel-select width
// helper and the default parameter values used by the interface and the top.
// ---------------------------------------------------------------------------
package clk_en_gen_pkg;

  // Lock qualification states, in the order the block normally walks them
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } lockState_e;

  // Default parameter values shared by the interface and the top level
  localparam int NCH_DEF       = 4;
  localparam int ACC_W_DEF     = 24;
  localparam int LOCK_CYC_DEF  = 1024;
  localparam int FWORD_DEF_VAL = 0;

  // Channel-select width; a single channel still gets a one-bit select so the
  // port never collapses to zero width
  function automatic int chanWidth(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// ---------------------------------------------------------------------------
// clk_en_gen_if
// Configuration port of clk_en_gen: a valid/ready transfer that writes one
// channel's frequency word and enable.
//   CFG_VALID  master->slave  config request
//   CFG_READY  slave->master  config accept
//   CFG_CHAN   master->slave  target channel
//   CFG_FWORD  master->slave  frequency word
//   CFG_EN     master->slave  channel enable
// ---------------------------------------------------------------------------
interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int ACC_W = ACC_W_DEF
) ();

  localparam int CHW = chanWidth(NCH);

  logic             CFG_VALID;
  logic             CFG_READY;
  logic [CHW-1:0]   CFG_CHAN;
  logic [ACC_W-1:0] CFG_FWORD;
  logic             CFG_EN;

  modport master (
    output CFG_VALID,
    output CFG_CHAN,
    output CFG_FWORD,
    output CFG_EN,
    input  CFG_READY
  );

  modport slave (
    input  CFG_VALID,
    input  CFG_CHAN,
    input  CFG_FWORD,
    input  CFG_EN,
    output CFG_READY
  );

endinterface

// File: rtl/nco_chan.sv
// ---------------------------------------------------------------------------
// nco_chan
// One phase-accumulator channel. Holds the active frequency word/enable, a
// shadow copy written by config transfers, and the pending flag that defers
// the shadow until the running period has completed.
//   i_clk, i_rstN  clock, asynchronous active-low reset
//   i_run          block is in RUN with lock still present this cycle
//   i_lost         block is in LOST: discard any pending config
//   i_sync         phase-realign strobe, already qualified with i_run
//   i_wr           config transfer addressed to this channel
//   i_wrFword      frequency word of the transfer
//   i_wrEn         enable of the transfer
//   o_ce           one-cycle pulse, the cycle after the overflowing add
//   o_sq           square wave, accumulator MSB
//   o_en           active enable
// ---------------------------------------------------------------------------
module nco_chan #(
  parameter int               ACC_W     = 24,
  parameter logic [ACC_W-1:0] FWORD_RST = '0
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_run,
  input  logic             i_lost,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_wrFword,
  input  logic             i_wrEn,
  output logic             o_ce,
  output logic             o_sq,
  output logic             o_en
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_actFword;
  logic [ACC_W-1:0] r_shFword;
  logic             r_actEn;
  logic             r_shEn;
  logic             r_pend;
  logic             r_ce;

  logic [ACC_W:0]   w_sum;
  logic             w_accum;
  logic             w_wrap;
  logic             w_applyNow;
  logic             w_applyShadow;
  logic [ACC_W-1:0] w_nextFword;
  logic             w_nextEn;

  // The extra top bit of the sum is the wrap carry
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_actFword};
  assign w_accum = i_run & r_actEn;
  assign w_wrap  = w_accum & w_sum[ACC_W];

  // Decide which frequency word/enable becomes active at the next edge. A
  // transfer lands straight in the active registers whenever nothing is
  // running on this channel, or when it coincides with a wrap or a SYNC (the
  // old period has just ended anyway). Otherwise it waits in the shadow and
  // is picked up by the next wrap or SYNC, so a running period is never cut
  // short.
  always_comb begin
    w_applyNow    = 1'b0;
    w_applyShadow = 1'b0;
    w_nextFword   = r_actFword;
    w_nextEn      = r_actEn;
    if (i_wr) begin
      w_applyNow = ~i_run | ~r_actEn | i_sync | w_wrap;
      if (w_applyNow) begin
        w_nextFword = i_wrFword;
        w_nextEn    = i_wrEn;
      end
    end else if (r_pend & i_run & (i_sync | w_wrap)) begin
      w_applyShadow = 1'b1;
      w_nextFword   = r_shFword;
      w_nextEn      = r_shEn;
    end
  end

  // Channel state. The accumulator is forced to zero whenever the channel
  // does not run, is being disabled, or is realigned by SYNC; the CE of a
  // SYNC cycle is suppressed because that add is thrown away.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_acc      <= '0;
      r_actFword <= FWORD_RST;
      r_shFword  <= FWORD_RST;
      r_actEn    <= 1'b0;
      r_shEn     <= 1'b0;
      r_pend     <= 1'b0;
      r_ce       <= 1'b0;
    end else begin
      r_actFword <= w_nextFword;
      r_actEn    <= w_nextEn;
      if (i_wr) begin
        r_shFword <= i_wrFword;
        r_shEn    <= i_wrEn;
      end
      if (i_lost) begin
        r_pend <= 1'b0;
      end else if (i_wr) begin
        r_pend <= ~w_applyNow;
      end else if (w_applyShadow) begin
        r_pend <= 1'b0;
      end
      r_ce  <= w_wrap & ~i_sync;
      r_acc <= (w_accum & w_nextEn & ~i_sync) ? w_sum[ACC_W-1:0] : '0;
    end
  end

  assign o_ce = r_ce;
  assign o_sq = r_acc[ACC_W-1];
  assign o_en = r_actEn;

endmodule

// File: rtl/clk_en_gen.sv
// ---------------------------------------------------------------------------
// clk_en_gen
// Lock-qualified, multi-channel fractional clock-enable generator. Runs in
// the PLL output clock domain; channels only run once the synchronised PLL
// lock has been stable for LOCK_CYC cycles.
//   CLKI         block clock (PLL CLKOP net)
//   RSTN         asynchronous active-low reset
//   PLL_LOCK     PLL lock, asynchronous to CLKI
//   cfg          config port (CFG_VALID/READY/CHAN/FWORD/EN)
//   SYNC         one-cycle phase-realign strobe
//   READY        clocks valid (state RUN)
//   CE           per-channel one-cycle enable pulse
//   SQ           per-channel square wave
//   CHAN_ACTIVE  channel enabled and READY
// ---------------------------------------------------------------------------
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int               NCH       = NCH_DEF,
  parameter int               ACC_W     = ACC_W_DEF,
  parameter int               LOCK_CYC  = LOCK_CYC_DEF,
  parameter logic [ACC_W-1:0] FWORD_DEF = ACC_W'(FWORD_DEF_VAL)
) (
  input  logic               CLKI,
  input  logic               RSTN,
  input  logic               PLL_LOCK,
  clk_en_gen_if.slave        cfg,
  input  logic               SYNC,
  output logic               READY,
  output logic [NCH-1:0]     CE,
  output logic [NCH-1:0]     SQ,
  output logic [NCH-1:0]     CHAN_ACTIVE
);

  localparam int CHW   = chanWidth(NCH);
  localparam int CNT_W = $clog2(LOCK_CYC);

  logic             r_lockMeta;
  logic             r_lockSync;
  lockState_e       r_state;
  lockState_e       w_nextState;
  logic [CNT_W-1:0] r_lockCnt;
  logic             r_ready;
  logic             r_cfgReady;

  logic             w_run;
  logic             w_sync;
  logic             w_xfer;
  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_en;

  // Two-flop synchroniser bringing the asynchronous PLL lock into CLKI
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_lockMeta <= 1'b0;
      r_lockSync <= 1'b0;
    end else begin
      r_lockMeta <= PLL_LOCK;
      r_lockSync <= r_lockMeta;
    end
  end

  // Next-state logic for lock qualification. Losing lock while running goes
  // through LOST for a single cycle so the channels can flush.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT_LOCK: begin
        if (r_lockSync) w_nextState = SETTLE;
      end
      SETTLE: begin
        if (!r_lockSync) begin
          w_nextState = WAIT_LOCK;
        end else if (r_lockCnt == CNT_W'(LOCK_CYC - 1)) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (!r_lockSync) w_nextState = LOST;
      end
      LOST: begin
        w_nextState = WAIT_LOCK;
      end
      default: begin
        w_nextState = WAIT_LOCK;
      end
    endcase
  end

  // State register plus the registered READY/CFG_READY flags, which are
  // decoded from the next state so they line up with the state they describe.
  // The settle counter only advances while staying in SETTLE.
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= WAIT_LOCK;
      r_lockCnt  <= '0;
      r_ready    <= 1'b0;
      r_cfgReady <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_ready    <= (w_nextState == RUN);
      r_cfgReady <= (w_nextState != LOST);
      if ((r_state == SETTLE) && (w_nextState == SETTLE)) begin
        r_lockCnt <= r_lockCnt + CNT_W'(1);
      end else begin
        r_lockCnt <= '0;
      end
    end
  end

  // Channels only run while in RUN and the lock is still present; a lock drop
  // therefore overrides a SYNC or a wrap in the same cycle.
  assign w_run  = (r_state == RUN) & r_lockSync;
  assign w_sync = SYNC & w_run;
  assign w_xfer = cfg.CFG_VALID & r_cfgReady;

  assign cfg.CFG_READY = r_cfgReady;

  // Per-channel decode; a channel number beyond NCH matches nothing, so such
  // a transfer is accepted and dropped
  for (genvar g = 0; g < NCH; g++) begin : gChan
    assign w_wr[g] = w_xfer & (cfg.CFG_CHAN == CHW'(g));

    nco_chan #(
      .ACC_W     (ACC_W),
      .FWORD_RST (FWORD_DEF)
    ) uChan (
      .i_clk     (CLKI),
      .i_rstN    (RSTN),
      .i_run     (w_run),
      .i_lost    (r_state == LOST),
      .i_sync    (w_sync),
      .i_wr      (w_wr[g]),
      .i_wrFword (cfg.CFG_FWORD),
      .i_wrEn    (cfg.CFG_EN),
      .o_ce      (CE[g]),
      .o_sq      (SQ[g]),
      .o_en      (w_en[g])
    );
  end

  assign READY       = r_ready;
  assign CHAN_ACTIVE = w_en & {NCH{r_ready}};

endmodule
